dec_scan: RTL and testbench

DEC_SCAN -- requirements
Module: dec_scan

---
 rtl/dec_scan.sv | 76 +++++++
 tb/tb_dec_scan.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/dec_scan.sv
// Registered 1-of-2**N decoder with a direct-select mode and a self-timed scan mode.
// In scan mode the index dwells DIV clocks per value and wraps after `last`.
module dec_scan #(
  parameter int N   = 3,
  parameter int DIV = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            mode,
  input  logic [N-1:0]    Din,
  input  logic [N-1:0]    last,
  output logic [2**N-1:0] Y,
  output logic [N-1:0]    idx,
  output logic            tick
);

  localparam int W  = 2**N;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [W-1:0]  y_q,    y_d;
  logic [N-1:0]  idx_q,  idx_d;
  logic [CW-1:0] cnt_q,  cnt_d;
  logic          tick_q, tick_d;

  function automatic logic [W-1:0] onehot(input logic [N-1:0] sel);
    logic [W-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    y_d    = '0;
    tick_d = 1'b0;
    if (en) begin
      if (!mode) begin
        // Direct decode; any partial dwell count is discarded.
        idx_d = Din;
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        cnt_d  = '0;
        // >= rather than == so a `last` lowered below idx returns to 0.
        idx_d  = (idx_q >= last) ? '0 : idx_q + N'(1);
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      y_d = onehot(idx_d);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q    <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      y_q    <= y_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign Y    = y_q;
  assign idx  = idx_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_dec_scan.sv
// Directed bench for dec_scan: a DIV=4 instance for the main behaviour and a
// DIV=1 instance for the every-edge scan case, both with N=3.
module tb_dec_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, mode;
  logic [2:0] din, last;
  logic [7:0] y;
  logic [2:0] idx;
  logic       tick;

  logic       en1, mode1;
  logic [2:0] din1, last1;
  logic [7:0] y1;
  logic [2:0] idx1;
  logic       tick1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dec_scan #(.N(3), .DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .Din(din), .last(last),
    .Y(y), .idx(idx), .tick(tick)
  );

  dec_scan #(.N(3), .DIV(1)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .mode(mode1), .Din(din1), .last(last1),
    .Y(y1), .idx(idx1), .tick(tick1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset pulse placed between edges.
  task automatic pulse_rst();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic check_main(input string tag, input logic [2:0] e_idx, input logic e_tick);
    logic [7:0] e_y;
    e_y = 8'h01 << e_idx;
    check({tag, ".Y"},    {24'd0, y},    {24'd0, e_y});
    check({tag, ".idx"},  {29'd0, idx},  {29'd0, e_idx});
    check({tag, ".tick"}, {31'd0, tick}, {31'd0, e_tick});
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; din = '0; last = '0;
    en1 = 1'b0; mode1 = 1'b0; din1 = '0; last1 = '0;

    // Reset state, observed without any clock edge.
    #3;
    check("rst.Y",    {24'd0, y},    32'h0);
    check("rst.idx",  {29'd0, idx},  32'h0);
    check("rst.tick", {31'd0, tick}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Direct sweep: Y follows Din one edge later, tick stays 0.
    en = 1'b1; mode = 1'b0;
    for (int d = 0; d < 8; d++) begin
      din = 3'(d);
      step();
      check_main($sformatf("direct%0d", d), 3'(d), 1'b0);
    end

    // Full scan from reset, last=7: advance on every 4th edge, wrap 7->0.
    pulse_rst();
    mode = 1'b1; last = 3'd7;
    for (int k = 1; k <= 36; k++) begin
      step();
      check_main($sformatf("scan7.e%0d", k), 3'((k / 4) % 8), (k % 4) == 0);
    end

    // Short scan, last=2: 0,1,2,0.
    pulse_rst();
    last = 3'd2;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k % 4 == 0) check_main($sformatf("scan2.e%0d", k), 3'((k / 4) % 3), 1'b1);
    end

    // idx=5 via direct mode, then scan from count 0; lower last to 2 mid-dwell.
    mode = 1'b0; din = 3'd5;
    step();
    check_main("lower.load", 3'd5, 1'b0);
    mode = 1'b1; last = 3'd7;
    step();
    step();
    check_main("lower.dwell", 3'd5, 1'b0);
    last = 3'd2;
    step();
    check_main("lower.hold", 3'd5, 1'b0);
    step();
    check_main("lower.wrap", 3'd0, 1'b1);

    // Enable freeze at idx=3, count=1.
    mode = 1'b0; din = 3'd3;
    step();
    mode = 1'b1; last = 3'd7;
    step();
    check_main("frz.pre", 3'd3, 1'b0);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("frz.Y",    {24'd0, y},    32'h0);
      check("frz.tick", {31'd0, tick}, 32'h0);
      check("frz.idx",  {29'd0, idx},  32'd3);
    end
    en = 1'b1;
    step();
    check_main("frz.res1", 3'd3, 1'b0);
    step();
    check_main("frz.res2", 3'd3, 1'b0);
    step();
    check_main("frz.adv", 3'd4, 1'b1);

    // Mode 1->0 takes Din on the same edge.
    mode = 1'b0; din = 3'd6;
    step();
    check_main("m10", 3'd6, 1'b0);

    // Async reset mid-scan at idx=6, between edges.
    mode = 1'b1;
    step();
    check_main("arst.pre", 3'd6, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("arst.Y",    {24'd0, y},    32'h0);
    check("arst.idx",  {29'd0, idx},  32'h0);
    check("arst.tick", {31'd0, tick}, 32'h0);
    #1 rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      check_main($sformatf("arst.e%0d", k), (k == 4) ? 3'd1 : 3'd0, k == 4);
    end

    // last=0: idx pinned at 0, tick still every 4 edges.
    pulse_rst();
    last = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check_main($sformatf("last0.e%0d", k), 3'd0, (k % 4) == 0);
    end

    // DIV=1, last=3: advance every edge, tick continuously high.
    en = 1'b0;
    pulse_rst();
    en1 = 1'b1; mode1 = 1'b1; last1 = 3'd3;
    for (int k = 1; k <= 8; k++) begin
      logic [7:0] e_y;
      step();
      e_y = 8'h01 << (k % 4);
      check($sformatf("div1.e%0d.Y", k),    {24'd0, y1},    {24'd0, e_y});
      check($sformatf("div1.e%0d.tick", k), {31'd0, tick1}, 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
